// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
//   state_e : arbiter FSM states (IDLE / ACCESS)
//   owner_e : which requester owns the current access (IF / DM)
//   word_align() : clears the byte-offset bits of a byte address
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return byte_addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count up by one (ignored once count reaches MAX)
//   clr        : clear to zero (takes priority over inc)
//   count      : current value
//   at_max     : count == MAX
module sat_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    logic [WIDTH-1:0] count_q;

    assign at_max = (count_q == WIDTH'(MAX));
    assign count  = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !at_max) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between the fetch
// stage (IF, read-only) and the memory stage (DM, read/write). DM wins by
// default; after STARVE_LIMIT blocked IF cycles the IF request wins once.
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr                  : fetch request, held until if_gnt
//   if_gnt/if_done/if_rdata         : fetch accept pulse, completion pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata   : data request, held until dm_gnt
//   dm_gnt/dm_done/dm_rdata         : data accept pulse, completion pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata: memory access (word-aligned address)
//   mem_rdata                       : memory read data, sampled at end of access
//   busy                            : an access is in progress
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned     LAT_W    = $clog2(MEM_LATENCY + 1);
    localparam int unsigned     STV_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

    state_e            state_q;
    owner_e            owner_q;
    logic [LAT_W-1:0]  lat_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;

    logic [STV_W-1:0]  starve_cnt;
    logic              starve_at_max;
    logic              if_starved;
    logic              idle;
    logic              grant_if;
    logic              grant_dm;

    // Grants are decided in the same IDLE cycle as the request so the
    // pipeline sees gnt without an extra bubble; held low during reset.
    always_comb begin
        idle       = (state_q == ST_IDLE) && !reset;
        if_starved = (starve_cnt >= STV_W'(STARVE_LIMIT));
        grant_dm   = idle && dm_req && !(if_req && if_starved);
        grant_if   = idle && if_req && !grant_dm;
    end

    // Counts consecutive cycles an IF request is left waiting.
    sat_counter #(
        .WIDTH (STV_W),
        .MAX   (STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (if_req && !grant_if && !starve_at_max),
        .clr    (grant_if || !if_req),
        .count  (starve_cnt),
        .at_max (starve_at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            lat_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_dm) begin
                        owner_q <= OWN_DM;
                        we_q    <= dm_we;
                        addr_q  <= word_align(dm_addr);
                        wdata_q <= dm_wdata;
                        lat_q   <= LAT_LOAD;
                        state_q <= ST_ACCESS;
                    end else if (grant_if) begin
                        owner_q <= OWN_IF;
                        we_q    <= 1'b0;
                        addr_q  <= word_align(if_addr);
                        wdata_q <= '0;
                        lat_q   <= LAT_LOAD;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (lat_q == '0) begin
                        state_q <= ST_IDLE;
                        if (owner_q == OWN_DM) begin
                            dm_done_q <= 1'b1;
                            if (!we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                        end else begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = (state_q == ST_ACCESS);
    assign busy      = (state_q == ST_ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random single transactions,
// checked against a word-level shadow of memory contents and the arbitration
// rules. A second instance runs with MEM_LATENCY=1 for back-to-back timing.
module tb_mem_arbiter;

    localparam int unsigned LAT0  = 2;
    localparam int unsigned LAT1  = 1;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_done, dm_gnt, dm_done;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_if_req, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
    logic        b_if_gnt, b_if_done, b_dm_gnt, b_dm_done;
    logic [31:0] b_if_rdata, b_dm_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(LAT0), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LATENCY(LAT1), .STARVE_LIMIT(LIMIT)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_done(b_dm_done), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Power-on memory contents: a fixed pattern per word index.
    function automatic logic [31:0] init_word(input int unsigned i);
        return 32'hC0DE_0000 ^ (i * 32'h0001_0101);
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    // Memory seen by the DUT (256 words, aliased on address bits 9:2).
    bit [31:0] mem0 [256] = '{default: 32'h0};
    bit        wr0  [256] = '{default: 1'b0};

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem0[mem_addr[9:2]] <= mem_wdata;
            wr0[mem_addr[9:2]]  <= 1'b1;
        end
    end

    assign mem_rdata   = wr0[mem_addr[9:2]] ? mem0[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));
    assign b_mem_rdata = init_word(int'(b_mem_addr[9:2]));

    // Reference view of memory: word index -> last committed write.
    logic [31:0] ref0 [int unsigned];
    logic [31:0] exp_dm, exp_if;

    function automatic logic [31:0] ref_read0(input logic [31:0] a);
        if (ref0.exists(widx(a))) return ref0[widx(a)];
        return init_word(widx(a));
    endfunction

    // Requester protocol: a request must stay up until it is granted.
    bit if_pend = 0, dm_pend = 0, b_pend = 0, proto_bad = 0;
    always @(posedge clk) begin
        if (reset) begin
            if_pend = 0; dm_pend = 0; b_pend = 0;
        end else begin
            assert (!(if_pend && !if_req)) else begin proto_bad = 1; $error("FAIL proto_if: if_req dropped before if_gnt"); end
            assert (!(dm_pend && !dm_req)) else begin proto_bad = 1; $error("FAIL proto_dm: dm_req dropped before dm_gnt"); end
            assert (!(b_pend && !b_dm_req)) else begin proto_bad = 1; $error("FAIL proto_b_dm: dm_req dropped before dm_gnt"); end
            if_pend = if_req && !if_gnt;
            dm_pend = dm_req && !dm_gnt;
            b_pend  = b_dm_req && !b_dm_gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One uncontended transaction on the LAT0 instance, from request to done.
    task automatic xact0(input bit is_dm, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (is_dm) begin
            dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1; if_addr = addr;
        end
        #1;
        chk("gnt_dm", dm_gnt, is_dm);
        chk("gnt_if", if_gnt, !is_dm);
        next_cycle();
        dm_req = 0; if_req = 0;
        for (int c = 0; c < LAT0; c++) begin
            #1;
            chk("mem_en", mem_en, 1);
            chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("mem_we", mem_we, we);
            if (we) chk("mem_wdata", mem_wdata, wdata);
            chk("done_early", {if_done, dm_done}, 0);
            next_cycle();
        end
        #1;
        chk("busy_end", busy, 0);
        if (is_dm) begin
            if (we) ref0[widx(addr)] = wdata;
            else    exp_dm = ref_read0(addr);
            chk("dm_done", dm_done, 1);
            chk("if_done_quiet", if_done, 0);
            chk("dm_rdata", dm_rdata, exp_dm);
        end else begin
            exp_if = ref_read0(addr);
            chk("if_done", if_done, 1);
            chk("dm_done_quiet", dm_done, 0);
            chk("if_rdata", if_rdata, exp_if);
            chk("dm_rdata_hold", dm_rdata, exp_dm);
        end
        next_cycle();
        chk("done_pulse", {if_done, dm_done}, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [31:0] baddr [6];
        int dm_before, dm_after, if_cnt;
        bit fin, prev_if, is_dm, we;

        exp_dm = '0; exp_if = '0;
        reset = 1;
        if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 1; dm_addr = 32'h44; dm_wdata = 32'h1234_5678;
        b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = '0; b_dm_wdata = '0;

        // Reset with requests pending: every output stays 0.
        next_cycle();
        next_cycle();
        #1;
        chk("rst_ctl", {if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, busy}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_b_busy", {b_busy, b_mem_en, b_dm_gnt}, 0);
        next_cycle();
        reset = 0; if_req = 0; dm_req = 0; dm_we = 0;
        next_cycle();

        // IF read @0x10: gnt cycle 0, mem_en cycles 1-2, done cycle 3.
        xact0(0, 0, 32'h10, '0);

        // DM write to unaligned 0x22 then read back from 0x20.
        xact0(1, 1, 32'h22, 32'hDEAD_BEEF);
        xact0(1, 0, 32'h20, '0);
        chk("readback", dm_rdata, 32'hDEAD_BEEF);

        // Both request with no starvation: DM first, IF when DM finishes.
        a = 32'h0000_0104; b = 32'h0000_0208;
        dm_req = 1; dm_we = 0; dm_addr = a; if_req = 1; if_addr = b;
        #1;
        chk("both_dm_gnt", dm_gnt, 1);
        chk("both_if_wait", if_gnt, 0);
        next_cycle();
        dm_req = 0;
        for (int c = 0; c < LAT0; c++) begin
            #1;
            chk("both_if_blocked", if_gnt, 0);
            next_cycle();
        end
        #1;
        exp_dm = ref_read0(a);
        chk("both_dm_done", dm_done, 1);
        chk("both_dm_rdata", dm_rdata, exp_dm);
        chk("both_if_gnt", if_gnt, 1);
        next_cycle();
        if_req = 0;
        for (int c = 0; c < LAT0; c++) next_cycle();
        #1;
        exp_if = ref_read0(b);
        chk("both_if_done", if_done, 1);
        chk("both_if_rdata", if_rdata, exp_if);
        next_cycle();

        // DM held continuously: IF wins once after LIMIT blocked cycles.
        a = 32'h8000_0010; b = 32'h0000_0330;
        dm_req = 1; dm_we = 0; dm_addr = a; if_req = 1; if_addr = b;
        dm_before = 0; dm_after = 0; if_cnt = 0; fin = 0; prev_if = 0;
        for (int c = 0; c < 60 && !fin; c++) begin
            #1;
            if (prev_if) chk("starve_clr", 32'(dut.starve_cnt), 0);
            chk("gnt_excl", {31'b0, dm_gnt & if_gnt}, 0);
            if (if_gnt) if_cnt++;
            if (dm_gnt) begin
                if (if_cnt == 0) dm_before++;
                else             dm_after++;
            end
            prev_if = if_gnt;
            next_cycle();
            if (prev_if) if_req = 0;
            if (dm_after > 0) begin
                dm_req = 0;
                fin = 1;
            end
        end
        chk("starve_timeout", {31'b0, fin}, 1);
        chk("dm_before_if", dm_before, (LIMIT + LAT0) / (LAT0 + 1));
        chk("if_gnt_count", if_cnt, 1);
        for (int c = 0; c < 10 && busy; c++) next_cycle();
        #1;
        chk("starve_drain", busy, 0);
        chk("starve_dm_rdata", dm_rdata, ref_read0(a));
        chk("starve_if_rdata", if_rdata, ref_read0(b));
        exp_dm = ref_read0(a); exp_if = ref_read0(b);
        next_cycle();

        // Reset in the middle of an access: aborted, no done pulse.
        dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0014;
        #1;
        chk("abort_gnt", dm_gnt, 1);
        next_cycle();
        dm_req = 0;
        #1;
        chk("abort_mem_en", mem_en, 1);
        reset = 1;
        next_cycle();
        #1;
        chk("abort_ctl", {if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, busy}, 0);
        chk("abort_dm_rdata", dm_rdata, 0);
        chk("abort_if_rdata", if_rdata, 0);
        chk("abort_mem_addr", mem_addr, 0);
        reset = 0;
        exp_dm = '0; exp_if = '0;
        next_cycle();
        #1;
        chk("abort_no_done", {if_done, dm_done, busy}, 0);
        next_cycle();
        xact0(1, 0, 32'h0000_0014, '0);

        // Random uncontended traffic against the reference memory.
        for (int n = 0; n < 24; n++) begin
            is_dm = ($urandom_range(0, 2) != 0);
            we    = is_dm && ($urandom_range(0, 1) == 1);
            a     = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            xact0(is_dm, we, a, $urandom);
        end

        // MEM_LATENCY=1, back-to-back DM reads: one access every 2 cycles.
        for (int k = 0; k < 6; k++) baddr[k] = $urandom;
        b_dm_req = 1; b_dm_we = 0; b_dm_addr = baddr[0];
        for (int k = 0; k <= 5; k++) begin
            #1;
            chk("b_gnt", b_dm_gnt, (k < 5) ? 1 : 0);
            if (k > 0) begin
                chk("b_done", b_dm_done, 1);
                chk("b_rdata", b_dm_rdata, init_word(widx(baddr[k-1])));
            end
            if (k == 5) break;
            next_cycle();
            if (k + 1 < 5) b_dm_addr = baddr[k+1];
            else           b_dm_req = 0;
            #1;
            chk("b_mem_en", {b_mem_en, b_busy}, 2'b11);
            chk("b_gnt_busy", {b_dm_gnt, b_dm_done, b_mem_we}, 0);
            chk("b_mem_addr", b_mem_addr, baddr[k] & 32'hFFFF_FFFC);
            chk("b_mem_wdata", b_mem_wdata, 0);
            next_cycle();
        end
        chk("b_if_side", {b_if_gnt, b_if_done}, 0);
        chk("b_if_rdata", b_if_rdata, 0);
        next_cycle();

        chk("protocol", {31'b0, proto_bad}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
